muldiv_unit: RTL

Iterative multiply/divide unit with HI/LO result registers, parametrised in operand width, that extends the single-cycle ALU's MUL/DIV capability into a multi-cycle, handshaked block. It sits beside the ALU in the execute stage. It takes two operands and an op code on a `start` pulse, computes over WIDTH cycles, and leaves the full double-width product, or the quotient and remainder, in HI/LO until the next operation completes. The core stalls on `busy`.

---
 rtl/muldiv_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO result registers
//
// Purpose: multi-cycle MULT/MULTU/DIV/DIVU beside the execute-stage ALU.
//   A start in IDLE captures op/a/b. One setup cycle converts operands to
//   magnitudes (or resolves a zero divisor). WIDTH shift-add or restoring
//   shift-subtract steps follow. In the signed build, a FIX cycle then
//   applies the recorded result signs.
// Macro: MULDIV_SIGNED_EN - when defined, ops 00/10 are signed and the FIX
//   state plus negation logic exist; when undefined, op[0] is ignored,
//   all ops are unsigned and RUN goes straight to DONE.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, op, a, b   - request (sampled in IDLE), op select, operands
//   busy, done        - busy from the cycle after acceptance through done;
//                       done is a one-cycle completion pulse
//   hi, lo            - product[2W-1:W]/[W-1:0] or remainder/quotient
//   div_by_zero       - set with done when a divide had a zero divisor
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               setup_q, setup_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;       // raw b, then multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;

    logic [WIDTH:0]     rem, diff, sum;
    logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
    logic sgn_q, sgn_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
`else
    logic op0_unused;
    assign op0_unused = op[0];
`endif

    // state register and all datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            setup_q  <= 1'b0;
            div_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            setup_q  <= setup_d;
            div_q    <= div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MULDIV_SIGNED_EN
            sgn_q    <= sgn_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
`endif
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (setup_q) begin
                    if (div_q && (b_q == '0)) state_d = S_DONE;
                end else if (cnt_q == '0) begin
`ifdef MULDIV_SIGNED_EN
                    state_d = S_FIX;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // datapath and registered outputs
    always_comb begin
        cnt_d    = cnt_q;
        setup_d  = setup_q;
        div_d    = div_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        rem      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = rem - {1'b0, b_q};
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
`ifdef MULDIV_SIGNED_EN
        sgn_d    = sgn_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        a_mag    = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        b_mag    = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
`else
        a_mag    = a_q;
        b_mag    = b_q;
`endif
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d   = op[1];
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = CW'(WIDTH - 1);
                    setup_d = 1'b1;
`ifdef MULDIV_SIGNED_EN
                    sgn_d   = ~op[0];
`endif
                end
            end
            S_RUN: begin
                if (setup_q) begin
                    setup_d = 1'b0;
                    if (state_d == S_DONE) begin
                        // zero divisor: dividend passes through unchanged
                        hi_d  = a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else if (div_q) begin
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                        b_d   = b_mag;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                        b_d   = a_mag;
                    end
`ifdef MULDIV_SIGNED_EN
                    neg_lo_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_hi_d = sgn_q & a_q[WIDTH-1];
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (div_q) begin
                        // restoring step: quotient bit enters at the bottom
                        acc_d = {(diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0]),
                                 acc_q[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        acc_d = {sum, acc_q[WIDTH-1:1]};
                    end
                    if (state_d == S_DONE) begin
                        hi_d  = acc_d[2*WIDTH-1:WIDTH];
                        lo_d  = acc_d[WIDTH-1:0];
                        dbz_d = 1'b0;
                    end
                end
            end
`ifdef MULDIV_SIGNED_EN
            S_FIX: begin
                dbz_d = 1'b0;
                if (div_q) begin
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
                end
            end
`endif
            default: ;
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
endmodule
